// File: rtl/uart_telemetry_tx.sv
// UART 8N1 telemetry transmitter: sends a 5-byte status packet (header, p1, p2, game_over, xor)
// whenever the synchronised score/game_over word changes or force_send is pulsed.
module uart_telemetry_tx #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] score_p1,
  input  logic [3:0] score_p2,
  input  logic       game_over,
  input  logic       force_send,
  output logic       uart_tx,
  output logic       busy,
  output logic       pkt_done
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       byte_q, byte_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             pending_q, pending_d;
  logic [8:0]       snap_q, snap_d;
  logic [8:0]       last_sent_q, last_sent_d;
  logic [8:0]       sync1_q, sync2_q, prev_q, stable_q;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [8:0]       stable_w;
  logic             change_w;
  logic             baud_end;

  function automatic logic [7:0] pkt_byte(input logic [2:0] idx, input logic [8:0] w);
    logic [7:0] b1, b2, b3;
    b1 = {4'h0, w[3:0]};
    b2 = {4'h0, w[7:4]};
    b3 = {7'h0, w[8]};
    case (idx)
      3'd0:    pkt_byte = HEADER;
      3'd1:    pkt_byte = b1;
      3'd2:    pkt_byte = b2;
      3'd3:    pkt_byte = b3;
      default: pkt_byte = b1 ^ b2 ^ b3;
    endcase
  endfunction

  // The word is only trusted once two consecutive synced samples agree, hiding multi-bit skew.
  assign stable_w = (sync2_q == prev_q) ? sync2_q : stable_q;
  assign change_w = (stable_w != last_sent_q);
  assign baud_end = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= {game_over, score_p2, score_p1};
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      stable_q <= stable_w;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      shreg_q     <= '0;
      pending_q   <= 1'b0;
      snap_q      <= '0;
      last_sent_q <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      shreg_q     <= shreg_d;
      pending_q   <= pending_d;
      snap_q      <= snap_d;
      last_sent_q <= last_sent_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    shreg_d     = shreg_q;
    pending_d   = pending_q | change_w | force_send;
    snap_d      = snap_q;
    last_sent_d = last_sent_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d     = START;
          cnt_d       = '0;
          byte_d      = 3'd0;
          shreg_d     = HEADER;
          snap_d      = stable_w;
          last_sent_d = stable_w;
          pending_d   = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          cnt_d   = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          cnt_d = '0;
          if (byte_q < 3'd4) begin
            byte_d  = byte_q + 3'd1;
            shreg_d = pkt_byte(byte_q + 3'd1, snap_q);
            state_d = START;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Line level is registered from the next state so the pin never glitches.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign uart_tx  = tx_q;
  assign busy     = busy_q;
  assign pkt_done = done_q;

endmodule
